// File: rtl/data_memory_bytewise.sv
// Byte-addressed data memory with byte/half/word access, registered loads and
// a zeroing sequencer that holds the block off-line after reset.
module data_memory_bytewise #(
  parameter int DEPTH          = 256,
  parameter int TAP_INDEX      = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        misaligned,
  output logic        ready,
  output logic [31:0] mem_tap
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] TAP_IDX  = AW'(TAP_INDEX);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_next;
  logic [AW-1:0] clr_cnt;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic          aligned;
  logic [3:0]    byte_en;
  logic [31:0]   lane_data;
  logic [31:0]   cur_word;
  logic [31:0]   merged_word;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic [31:0]   load_value;
  logic          do_write, do_read, reject;
  logic          unused_addr_bits;

  // Upper address bits are deliberately ignored so accesses wrap.
  assign idx              = address[AW+1:2];
  assign unused_addr_bits = ^address[31:AW+2];
  assign cur_word         = mem[idx];
  assign ready            = (state == RUN);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    aligned   = 1'b1;
    byte_en   = 4'b1111;
    lane_data = write_data;
    case (mem_size)
      2'b00: begin
        byte_en   = 4'b0001 << address[1:0];
        lane_data = {4{write_data[7:0]}};
      end
      2'b01: begin
        aligned   = ~address[0];
        byte_en   = address[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{write_data[15:0]}};
      end
      default: aligned = (address[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged_word[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

  always_comb begin
    load_byte = cur_word[8*address[1:0] +: 8];
    load_half = address[1] ? cur_word[31:16] : cur_word[15:0];
    case (mem_size)
      2'b00:   load_value = {{24{~mem_unsigned & load_byte[7]}}, load_byte};
      2'b01:   load_value = {{16{~mem_unsigned & load_half[15]}}, load_half};
      default: load_value = cur_word;
    endcase
  end

  // A simultaneous write and read resolves to the write alone.
  assign do_write = ready & MemWrite & aligned;
  assign do_read  = ready & MemRead & ~MemWrite & aligned;
  assign reject   = ready & (MemWrite | MemRead) & ~aligned;

  always_comb begin
    state_next = state;
    if (state == CLEAR && (CLEAR_ON_RESET == 0 || clr_cnt == LAST_IDX)) begin
      state_next = RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      misaligned <= 1'b0;
      mem_tap    <= '0;
    end else begin
      state      <= state_next;
      read_valid <= do_read;
      misaligned <= reject;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (do_read) read_data <= load_value;
      if (state == RUN) begin
        mem_tap <= (do_write && idx == TAP_IDX) ? merged_word : mem[TAP_INDEX];
      end else begin
        mem_tap <= '0;
      end
    end
  end

  // NOTE: the array has no reset; zeroing is done one word per cycle by the CLEAR sequencer.
  always_ff @(posedge Clock) begin
    if (state == CLEAR && CLEAR_ON_RESET != 0) begin
      mem[clr_cnt] <= '0;
    end else if (do_write) begin
      mem[idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_data_memory_bytewise.sv
// Randomized and directed bench for data_memory_bytewise against a byte-array model.
module tb_data_memory_bytewise;

  localparam int DEPTH = 256;
  localparam int TAP   = 5;
  localparam int NBYTE = 4 * DEPTH;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [1:0]  mem_size = '0;
  logic        mem_unsigned = 1'b0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        misaligned;
  logic        ready;
  logic [31:0] mem_tap;

  data_memory_bytewise #(.DEPTH(DEPTH), .TAP_INDEX(TAP), .CLEAR_ON_RESET(1)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .address(address), .write_data(write_data),
    .MemWrite(MemWrite), .MemRead(MemRead), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .read_data(read_data), .read_valid(read_valid),
    .misaligned(misaligned), .ready(ready), .mem_tap(mem_tap)
  );

  always #5 Clock = ~Clock;

  int vectors = 0;
  int errors  = 0;

  // Reference model: flat byte array plus expected outputs.
  logic [7:0]  mb [NBYTE];
  bit          m_ready;
  int          clear_left;
  logic [31:0] e_rd, e_tap;
  bit          e_rv, e_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  task automatic model_reset();
    m_ready    = 1'b0;
    clear_left = DEPTH;
    e_rd = '0; e_tap = '0; e_rv = 1'b0; e_mis = 1'b0;
  endtask

  task automatic model_edge();
    int          n, base;
    bit          al;
    logic [31:0] v;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    if (m_ready) begin
      n    = (mem_size == 2'd0) ? 1 : (mem_size == 2'd1) ? 2 : 4;
      base = int'(address % NBYTE);
      al   = (base % n) == 0;
      e_rv = 1'b0; e_mis = 1'b0;
      if ((MemWrite || MemRead) && !al) begin
        e_mis = 1'b1;
      end else if (MemWrite) begin
        for (int i = 0; i < n; i++) mb[base+i] = write_data[8*i +: 8];
      end else if (MemRead) begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base+i];
        if (!mem_unsigned && n < 4 && v[8*n-1]) begin
          for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        end
        e_rd = v;
        e_rv = 1'b1;
      end
      e_tap = model_word(TAP);
    end else begin
      e_rv = 1'b0; e_mis = 1'b0; e_tap = '0;
      clear_left--;
      if (clear_left == 0) begin
        m_ready = 1'b1;
        for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
      end
    end
  endtask

  // One clock: advance model at the edge, compare all outputs 1 time unit later.
  task automatic step();
    @(posedge Clock);
    model_edge();
    #1;
    check("ready",      {31'b0, ready},      {31'b0, m_ready});
    check("read_valid", {31'b0, read_valid}, {31'b0, e_rv});
    check("misaligned", {31'b0, misaligned}, {31'b0, e_mis});
    check("read_data",  read_data, e_rd);
    check("mem_tap",    mem_tap,   e_tap);
  endtask

  task automatic op(input bit we, input bit re, input logic [31:0] a,
                    input logic [31:0] wd, input logic [1:0] sz, input bit uns);
    MemWrite = we; MemRead = re; address = a; write_data = wd;
    mem_size = sz; mem_unsigned = uns;
    step();
  endtask

  task automatic rand_op();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FC00;
    if ($urandom_range(0, 3) != 0) a = a | 32'($urandom_range(0, 47));
    else                           a = a | 32'($urandom_range(0, NBYTE-1));
    op(1'($urandom), 1'($urandom), a, $urandom, 2'($urandom), 1'($urandom));
  endtask

  task automatic count_clear(input string name);
    int low_cnt = 0;
    while (ready === 1'b0 && low_cnt < 400) begin
      low_cnt++;
      rand_op();
    end
    check(name, 32'(low_cnt), 32'd256);
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    check("reset_tap", mem_tap, 32'h0);
    Reset_n = 1'b1;
    count_clear("clear_len");

    op(0, 1, 32'h0,   0, 2'd2, 0); check("lw_0",   read_data, 32'h0);
    check("lw_0_valid", {31'b0, read_valid}, 32'd1);
    op(0, 1, 32'h14,  0, 2'd2, 0); check("lw_14",  read_data, 32'h0);
    op(0, 1, 32'h3FC, 0, 2'd2, 0); check("lw_3fc", read_data, 32'h0);
    op(0, 0, 32'h0,   0, 2'd2, 0); check("rv_drop", {31'b0, read_valid}, 32'd0);
    check("rd_hold", read_data, 32'h0);

    op(1, 0, 32'h14, 32'hDEADBEEF, 2'd2, 0); check("tap_fwd", mem_tap, 32'hDEADBEEF);
    op(0, 1, 32'h14, 0, 2'd0, 0); check("lb_14", read_data, 32'hFFFFFFEF);
    op(0, 1, 32'h15, 0, 2'd0, 0); check("lb_15", read_data, 32'hFFFFFFBE);
    op(0, 1, 32'h16, 0, 2'd0, 0); check("lb_16", read_data, 32'hFFFFFFAD);
    op(0, 1, 32'h17, 0, 2'd0, 0); check("lb_17", read_data, 32'hFFFFFFDE);
    op(0, 1, 32'h17, 0, 2'd0, 1); check("lbu_17", read_data, 32'h000000DE);

    op(1, 0, 32'h20, 32'h11223344, 2'd2, 0);
    op(1, 0, 32'h22, 32'h00008001, 2'd1, 0);
    op(0, 1, 32'h20, 0, 2'd2, 0); check("lw_20", read_data, 32'h80013344);
    op(0, 1, 32'h22, 0, 2'd1, 0); check("lh_22", read_data, 32'hFFFF8001);

    op(0, 1, 32'h21, 0, 2'd1, 0); check("mis_lh", {31'b0, misaligned}, 32'd1);
    check("mis_lh_rv", {31'b0, read_valid}, 32'd0);
    op(1, 0, 32'h26, 32'hCAFEF00D, 2'd2, 0); check("mis_sw", {31'b0, misaligned}, 32'd1);
    op(0, 1, 32'h24, 0, 2'd2, 0); check("lw_24", read_data, 32'h0);
    check("mis_drop", {31'b0, misaligned}, 32'd0);

    op(1, 1, 32'h8, 32'h5, 2'd2, 0); check("wr_rd_rv", {31'b0, read_valid}, 32'd0);
    op(0, 1, 32'h8,   0, 2'd2, 0); check("lw_8",   read_data, 32'h5);
    op(0, 1, 32'h408, 0, 2'd2, 0); check("lw_408", read_data, 32'h5);

    repeat (1500) rand_op();

    Reset_n = 1'b0;
    #1 check("async_ready", {31'b0, ready}, 32'd0);
    step();
    Reset_n = 1'b1;
    repeat (100) rand_op();
    Reset_n = 1'b0;
    step();
    step();
    Reset_n = 1'b1;
    count_clear("clear_restart");
    op(0, 1, 32'h14, 0, 2'd2, 0); check("lw_14_cleared", read_data, 32'h0);
    repeat (300) rand_op();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_bytewise.md
Name: data_memory_bytewise

Overview:
- Parametrised successor to the single-cycle 32-bit data memory: byte-addressed, with byte/half/word stores and loads and sign/zero extension on loads.
- Synchronous registered read with a valid strobe, misalignment detection, and a hardware clear-on-reset sequencer.
- Sits between the MIPS datapath ALU result/rt operand and the writeback mux.
- Exposes a registered tap of one configurable word for the seven-segment display path.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, 4..4096.
- TAP_INDEX, 5, word index mirrored on mem_tap; 0..DEPTH-1.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset via sequencer; 0 = skip clear, contents undefined.

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- address  input  32  byte address. Word index = address[log2(DEPTH)+1:2]; upper bits ignored, so addresses wrap modulo 4*DEPTH.
- write_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- MemWrite  input  1  store request, sampled each rising edge.
- MemRead  input  1  load request, sampled each rising edge.
- mem_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_unsigned  input  1  1 = zero-extend byte/half loads; 0 = sign-extend.
- read_data  output  32  load result, extended to 32 bits.
- read_valid  output  1  one-cycle strobe: read_data updated this cycle.
- misaligned  output  1  one-cycle strobe: rejected access.
- ready  output  1  1 = block accepts requests.
- mem_tap  output  32  registered copy of memory[TAP_INDEX].

Behaviour:
- Reset (Reset_n low, async):
  - read_data=0, read_valid=0, misaligned=0, ready=0, mem_tap=0.
  - FSM returns to CLEAR; clear counter = 0.
  - Memory array is not reset asynchronously.
- FSM states:
  - CLEAR: one word per cycle written to 0 at index counter; counter increments. After index DEPTH-1 is written, go to RUN next edge and ready goes high. CLEAR lasts exactly DEPTH cycles after reset release. With CLEAR_ON_RESET=0, go directly to RUN on the first edge after release.
  - While ready=0, MemWrite/MemRead are ignored: no write, no strobes.
  - RUN: ready=1; service requests. Stays in RUN until reset.
- Reset asserted mid-CLEAR restarts the clear from index 0.
- Alignment:
  - half requires address[0]=0; word requires address[1:0]=00; byte is always aligned.
  - A misaligned access (read or write) is not performed. misaligned=1 for one cycle after the edge; read_valid=0; memory unchanged.
- Store (MemWrite=1 in RUN), updates only the addressed lanes:
  - byte: lane address[1:0] gets write_data[7:0].
  - half: lanes {address[1],1},{address[1],0} get write_data[15:0].
  - word: all four lanes.
- Load (MemRead=1, MemWrite=0 in RUN):
  - 1-cycle latency: read_data and read_valid=1 are valid after the sampling edge.
  - read_valid deasserts the next cycle unless another load is issued.
  - read_data holds its value between loads.
  - Byte/half extraction uses the same lane selection as stores, extended per mem_unsigned.
- Simultaneous MemWrite and MemRead: the write wins; no load, read_valid=0.
- Back-to-back: a load in the cycle after a store to the same word returns the new data; no stall required.
- mem_tap:
  - Updated every edge in RUN.
  - A store hitting TAP_INDEX is forwarded: mem_tap shows the merged new word at the same edge the write occurs.
  - Held at 0 through CLEAR.
- Little-endian lane order: byte 0 = bits [7:0].

Test Plan:
- Reset release with DEPTH=256, CLEAR_ON_RESET=1 -> ready low exactly 256 cycles; then word loads at addresses 0x0, 0x14, 0x3FC return 0x00000000 with read_valid one cycle after request.
- Word store 0xDEADBEEF @0x14, then byte loads @0x14..0x17 signed -> 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE; unsigned byte @0x17 -> 0x000000DE; mem_tap=0xDEADBEEF at the store edge.
- Half store 0x8001 @0x22 onto word 0x11223344 -> word load @0x20 = 0x80013344; signed half load @0x22 = 0xFFFF8001.
- Half load @0x21 and word store @0x26 -> misaligned pulses one cycle each; read_valid stays 0; word @0x24 is unchanged.
- MemWrite and MemRead together, store 0x5 @0x8 -> write done, no read_valid; next-cycle load @0x8 = 0x00000005. Address 0x408 (DEPTH=256) aliases to 0x8.
- Reset pulsed at clear cycle 100 -> ready low for a further full 256 cycles after release; all requests during clear produce no strobes.
